spi_frame_master: RTL and testbench
===================================

# spi_frame_master

Synthesizable, parametrised master for the single-wire framed serial protocol: accepts config/start/read requests on a valid/ready interface, serialises header and payload LSB-first under `frame`, turns the line around for reads and returns sampled read data. Honours `suspend` bit-stalls and aborts frames stalled too long. Sits between the control logic and the pad-level tristate driver (`serial` inout is built at top level from `sdo`/`sdo_oe`/`sdi`).

## Interface
- `HDR_W`, 8, header bits per frame
- `DATA_W`, 8, config payload bits
- `RD_W`, 9, read response bits sampled
- `TURN_CYC`, 1, bus-turnaround cycles before read sampling (≥1)
- `GAP_CYC`, 2, idle cycles after frame before next accept (≥1)
- `SUSP_MAX`, 64, consecutive suspended cycles inside a frame before abort
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-low reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — request accepted when both high
- `req_op` in 2 — `OP_CFG`/`OP_START`/`OP_READ` (pkg)
- `req_data` in DATA_W — config payload (ignored for other ops)
- `rsp_valid` out 1 — one-cycle completion pulse
- `rsp_err` out 1 — qualifies `rsp_valid`: frame aborted
- `rsp_data` out RD_W — read data (zero for non-read/aborted)
- `frame` out 1 — frame strobe
- `sdo` out 1 — serial data out
- `sdo_oe` out 1 — drive enable for `serial`
- `sdi` in 1 — serial data in
- `suspend` in 1 — slave stall request

## Operation
- States: IDLE, HDR, DATA, TURN, RDAT, GAP.
- Reset (rst=0 at an edge): state IDLE; `frame`,`sdo`,`sdo_oe`,`rsp_valid`,`rsp_err`=0; `rsp_data`=0; counters 0. Mid-frame reset drops the frame immediately, no response.
- `req_ready` = (state==IDLE) & !suspend.
- Header by op: `OP_CFG`→`HDR_CFG`, `OP_START`→`HDR_START`, `OP_READ`→`HDR_READ`; op value 3 → `HDR_CFG` inverted and treated as CFG (illegal-header generation for checker tests).
- HDR: HDR_W bits, `hdr[0]` first. Then CFG→DATA (DATA_W bits, `req_data[0]` first); START→GAP; READ→TURN.
- TURN: `sdo_oe`=0, `sdo`=0, `frame`=1 for TURN_CYC cycles, then RDAT.
- RDAT: RD_W cycles, `sdi` captured into `rsp_data[i]`, i=0 first, at the rising edge ending each unsuspended RDAT cycle.
- GAP: `frame`=0, `sdo_oe`=0, `sdo`=0 for GAP_CYC cycles; `rsp_valid` pulses in first GAP cycle; then IDLE.
- Suspend: at any edge inside HDR/DATA/TURN/RDAT with `suspend`=1, no state/counter advance, outputs hold, no `sdi` capture. GAP counts through suspend.
- Abort: suspend counter (clears on any unsuspended cycle) reaching SUSP_MAX → GAP with `rsp_err`=1, `rsp_data`=0.
- Counters sized `$clog2(max+1)`; no wrap possible within a frame.

## Timing
- Accept at edge T; from T+1: `frame`=1, `sdo_oe`=1, `sdo`=hdr[0].
- Unsuspended frame lengths (cycles of `frame`=1): START HDR_W; CFG HDR_W+DATA_W; READ HDR_W+TURN_CYC+RD_W.
- `frame` falls in first GAP cycle, same cycle as `rsp_valid`.
- Earliest next accept: GAP_CYC cycles after `frame` falls (defaults: 2).
- `suspend` high in IDLE holds `req_ready` low; request waits, never dropped.

## Structure
- Package `spi_frame_pkg`: `op_e` enum (`OP_CFG`=0,`OP_START`=1,`OP_READ`=2,`OP_BADHDR`=3), header constants `HDR_CFG`=8'hC3, `HDR_START`=8'h5A, `HDR_READ`=8'h96, state enum.
- One sub-module `spi_shift_ctr`: bit counter with load, suspend-gated enable and terminal-count flag; instanced once, reloaded per phase.
- Top level (outside block) forms `serial = sdo_oe ? sdo : 1'bz`, `sdi = serial`.

## Test plan
- CFG `req_data`=8'h02, no suspend → `sdo` sequence C3 LSB-first then 0,1,0,0,0,0,0,0; `frame` high 16 cycles; `rsp_valid`, `rsp_err`=0.
- START → 8 frame cycles carrying 5A; next `req_ready` exactly 2 cycles after `frame` falls.
- READ, slave drives 9'h1A5 LSB-first after 1 turnaround cycle with `sdo_oe`=0 → `rsp_data`=9'h1A5, frame 18 cycles.
- CFG with `suspend` high 3 cycles during header bit 4 → bit 4 held 4 cycles, frame 19 cycles, payload intact.
- READ with `suspend` held 64 cycles in RDAT → frame drops, `rsp_valid`&`rsp_err`=1, `rsp_data`=0.
- `rst`=0 mid-DATA → next cycle all outputs 0, no `rsp_valid`; following CFG completes normally.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg
//   Shared definitions for the framed single-wire serial master:
//   request opcodes, per-opcode header patterns and FSM state codes.
package spi_frame_pkg;

    // Request opcodes carried on req_op.
    typedef enum logic [1:0] {
        OP_CFG    = 2'd0,
        OP_START  = 2'd1,
        OP_READ   = 2'd2,
        OP_BADHDR = 2'd3
    } op_e;

    // Header patterns, sent LSB first.
    localparam logic [7:0] HDR_CFG   = 8'hC3;
    localparam logic [7:0] HDR_START = 8'h5A;
    localparam logic [7:0] HDR_READ  = 8'h96;

    // FSM state codes.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_TURN = 3'd3;
    localparam state_t ST_RDAT = 3'd4;
    localparam state_t ST_GAP  = 3'd5;

    // OP_BADHDR sends the inverted CFG header so downstream checkers can be
    // exercised with a header they must reject; the frame is otherwise a CFG.
    function automatic logic [7:0] hdr_for_op(input op_e op);
        logic [7:0] hdr;
        case (op)
            OP_CFG:   hdr = HDR_CFG;
            OP_START: hdr = HDR_START;
            OP_READ:  hdr = HDR_READ;
            default:  hdr = ~HDR_CFG;
        endcase
        return hdr;
    endfunction

endpackage

// File: rtl/spi_frame_master_ctr.sv
// spi_shift_ctr
//   Down-counter used as the phase bit counter. Loaded with (length-1) at the
//   start of each phase; tc flags the last cycle of the phase.
//   Ports:
//     clk, rst   - clock, synchronous active-low reset
//     load       - load load_val (has priority over counting)
//     load_val   - phase length minus one
//     en         - counting enabled in this state
//     hold       - stall (slave suspend); blocks counting when high
//     tc         - counter is at zero (last cycle of the phase)
module spi_shift_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             hold,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && !hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master
//   Master for the framed single-wire serial protocol. Accepts CFG / START /
//   READ requests, sends an LSB-first header (and payload for CFG) under
//   frame, turns the line around for READ and samples the response.
//   The slave may stall any in-frame cycle with suspend; a stall lasting
//   SUSP_MAX consecutive cycles aborts the frame with rsp_err.
//   Ports:
//     clk, rst          - clock, synchronous active-low reset
//     req_valid/ready   - request handshake
//     req_op, req_data  - opcode and CFG payload
//     rsp_valid         - one-cycle completion pulse (first gap cycle)
//     rsp_err           - qualifies rsp_valid: frame was aborted
//     rsp_data          - read data (zero for non-read or aborted frames)
//     frame, sdo, sdo_oe- serial line outputs to the pad driver
//     sdi               - serial line input from the pad
//     suspend           - slave stall request
//     dbg_state         - current FSM state (observability)
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready depends only on FSM state and
//   suspend, never on req_valid; a requester holds req_valid/op/data stable
//   until the transfer, and a request is never dropped while waiting.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int HDR_W    = 8,
    parameter int DATA_W   = 8,
    parameter int RD_W     = 9,
    parameter int TURN_CYC = 1,
    parameter int GAP_CYC  = 2,
    parameter int SUSP_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [RD_W-1:0]   rsp_data,
    output logic              frame,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic              sdi,
    input  logic              suspend,
    output state_t            dbg_state
);

    localparam int MAX_A   = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int MAX_B   = (RD_W > TURN_CYC) ? RD_W : TURN_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LEN = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int SUSP_W  = $clog2(SUSP_MAX + 1);

    state_t            state_q, state_d;
    op_e               op_q, op_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RD_W-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [SUSP_W-1:0] susp_cnt_q, susp_cnt_d;

    logic              ctr_load;
    logic [CNT_W-1:0]  ctr_load_val;
    logic              ctr_en;
    logic              ctr_hold;
    logic              ctr_tc;
    logic              in_frame;
    logic              abort;
    logic              enter_gap;

    spi_shift_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .en       (ctr_en),
        .hold     (ctr_hold),
        .tc       (ctr_tc)
    );

    assign in_frame  = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                       (state_q == ST_TURN) || (state_q == ST_RDAT);
    assign req_ready = (state_q == ST_IDLE) && !suspend;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        hdr_d        = hdr_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        susp_cnt_d   = '0;
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        ctr_en       = 1'b0;
        ctr_hold     = suspend;
        abort        = 1'b0;
        enter_gap    = 1'b0;

        // Consecutive-stall watchdog; any unsuspended cycle clears it.
        if (in_frame && suspend) begin
            if (susp_cnt_q == SUSP_W'(SUSP_MAX - 1)) begin
                abort = 1'b1;
            end else begin
                susp_cnt_d = susp_cnt_q + SUSP_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d      = ST_HDR;
                    op_d         = op_e'(req_op);
                    hdr_d        = HDR_W'(hdr_for_op(op_e'(req_op)));
                    data_d       = req_data;
                    rsp_data_d   = '0;
                    ctr_load     = 1'b1;
                    ctr_load_val = CNT_W'(HDR_W - 1);
                end
            end
            ST_HDR: begin
                ctr_en = 1'b1;
                if (!suspend) begin
                    if (ctr_tc) begin
                        case (op_q)
                            OP_START: enter_gap = 1'b1;
                            OP_READ: begin
                                state_d      = ST_TURN;
                                ctr_load     = 1'b1;
                                ctr_load_val = CNT_W'(TURN_CYC - 1);
                            end
                            default: begin
                                state_d      = ST_DATA;
                                ctr_load     = 1'b1;
                                ctr_load_val = CNT_W'(DATA_W - 1);
                            end
                        endcase
                    end else begin
                        hdr_d = hdr_q >> 1;
                    end
                end
            end
            ST_DATA: begin
                ctr_en = 1'b1;
                if (!suspend) begin
                    if (ctr_tc) begin
                        enter_gap = 1'b1;
                    end else begin
                        data_d = data_q >> 1;
                    end
                end
            end
            ST_TURN: begin
                ctr_en = 1'b1;
                if (!suspend && ctr_tc) begin
                    state_d      = ST_RDAT;
                    ctr_load     = 1'b1;
                    ctr_load_val = CNT_W'(RD_W - 1);
                end
            end
            ST_RDAT: begin
                ctr_en = 1'b1;
                if (!suspend) begin
                    // Shift in from the top so the first sampled bit lands in bit 0.
                    rsp_data_d = {sdi, rsp_data_q[RD_W-1:1]};
                    if (ctr_tc) begin
                        enter_gap = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // The gap is a fixed idle period; the slave cannot stretch it.
                ctr_en   = 1'b1;
                ctr_hold = 1'b0;
                if (ctr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            enter_gap  = 1'b1;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
        end

        if (enter_gap) begin
            state_d      = ST_GAP;
            rsp_valid_d  = 1'b1;
            ctr_load     = 1'b1;
            ctr_load_val = CNT_W'(GAP_CYC - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_CFG;
            hdr_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            susp_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            susp_cnt_q  <= susp_cnt_d;
        end
    end

    // Line outputs are decoded from registered state, so a suspended cycle
    // holds them simply because nothing advances.
    always_comb begin
        frame  = in_frame;
        sdo_oe = (state_q == ST_HDR) || (state_q == ST_DATA);
        sdo    = 1'b0;
        if (state_q == ST_HDR) begin
            sdo = hdr_q[0];
        end else if (state_q == ST_DATA) begin
            sdo = data_q[0];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master
//   Directed plus randomized frames against a slot-based reference model:
//   each frame is a list of line slots (header bits, payload bits, turnaround
//   and read cycles); a slot is consumed on every unsuspended cycle.
module tb_spi_frame_master;
    import spi_frame_pkg::*;

    localparam int HDR_W    = 8;
    localparam int DATA_W   = 8;
    localparam int RD_W     = 9;
    localparam int TURN_CYC = 1;
    localparam int GAP_CYC  = 2;
    localparam int SUSP_MAX = 64;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_err;
    logic [RD_W-1:0]   rsp_data;
    logic              frame;
    logic              sdo;
    logic              sdo_oe;
    logic              sdi;
    logic              suspend;
    state_t            dbg_state;

    spi_frame_master #(
        .HDR_W    (HDR_W),
        .DATA_W   (DATA_W),
        .RD_W     (RD_W),
        .TURN_CYC (TURN_CYC),
        .GAP_CYC  (GAP_CYC),
        .SUSP_MAX (SUSP_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .frame     (frame),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .sdi       (sdi),
        .suspend   (suspend),
        .dbg_state (dbg_state)
    );

    // Scoreboard
    int checks = 0;
    int errors = 0;
    logic [RD_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_hdr(input logic [1:0] op);
        case (op)
            2'd0:    return 8'hC3;
            2'd1:    return 8'h5A;
            2'd2:    return 8'h96;
            default: return 8'h3C;
        endcase
    endfunction

    // Driver: one complete request. susp_* give the frame-cycle window in
    // which suspend is held; idle_susp stalls the request in IDLE first;
    // rst_at >= 0 pulls reset in that frame cycle.
    task automatic do_frame(input logic [1:0] op, input logic [DATA_W-1:0] data,
                            input logic [RD_W-1:0] rd_word, input int susp_start,
                            input int susp_len, input int idle_susp, input int rst_at);
        logic [7:0] hdr;
        bit slot_sdo[$];
        bit slot_oe[$];
        int rd_base;
        int k;
        int c;
        int consec;
        int w;
        bit aborted;
        logic [RD_W-1:0] exp_rd;

        hdr = ref_hdr(op);
        rd_base = -1;
        for (int i = 0; i < HDR_W; i++) begin
            slot_sdo.push_back(hdr[i]);
            slot_oe.push_back(1'b1);
        end
        if (op == 2'd0 || op == 2'd3) begin
            for (int i = 0; i < DATA_W; i++) begin
                slot_sdo.push_back(data[i]);
                slot_oe.push_back(1'b1);
            end
        end
        if (op == 2'd2) begin
            for (int i = 0; i < TURN_CYC; i++) begin
                slot_sdo.push_back(1'b0);
                slot_oe.push_back(1'b0);
            end
            rd_base = slot_sdo.size();
            for (int i = 0; i < RD_W; i++) begin
                slot_sdo.push_back(1'b0);
                slot_oe.push_back(1'b0);
            end
        end
        exp_q.push_back((op == 2'd2) ? rd_word : '0);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        suspend   = (idle_susp > 0);
        for (int i = 0; i < idle_susp; i++) begin
            #1;
            check("ready_held_by_suspend", req_ready, 1'b0);
            check("idle_frame", frame, 1'b0);
            @(negedge clk);
        end
        suspend = 1'b0;
        #1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("ready_wait", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        k = 0;
        c = 0;
        consec = 0;
        aborted = 1'b0;
        while (1) begin
            suspend = (c >= susp_start) && (c < susp_start + susp_len);
            if (rd_base >= 0 && k >= rd_base && k < rd_base + RD_W) begin
                sdi = rd_word[k - rd_base];
            end else begin
                sdi = 1'($urandom_range(0, 1));
            end
            #1;
            check("frame", frame, 1'b1);
            check("sdo_oe", sdo_oe, slot_oe[k]);
            check("sdo", sdo, slot_sdo[k]);
            check("rsp_valid_in_frame", rsp_valid, 1'b0);
            if (rst_at == c) begin
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                suspend = 1'b0;
                #1;
                check("rst_frame", frame, 1'b0);
                check("rst_sdo", sdo, 1'b0);
                check("rst_sdo_oe", sdo_oe, 1'b0);
                check("rst_rsp_valid", rsp_valid, 1'b0);
                check("rst_rsp_err", rsp_err, 1'b0);
                check("rst_rsp_data", rsp_data, '0);
                rst = 1'b1;
                void'(exp_q.pop_front());
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    #1;
                    check("post_rst_no_rsp", rsp_valid, 1'b0);
                    check("post_rst_ready", req_ready, 1'b1);
                end
                return;
            end
            @(posedge clk);
            if (suspend) begin
                consec++;
            end else begin
                consec = 0;
                k++;
            end
            c++;
            @(negedge clk);
            if (consec == SUSP_MAX) begin
                aborted = 1'b1;
                break;
            end
            if (k == slot_sdo.size()) break;
            if (c > 400) begin
                check("frame_cycle_budget", 32'd0, 32'd1);
                break;
            end
        end

        // First gap cycle: frame falls together with the response pulse.
        suspend = 1'b0;
        exp_rd = exp_q.pop_front();
        if (aborted) exp_rd = '0;
        #1;
        check("gap_frame", frame, 1'b0);
        check("gap_sdo_oe", sdo_oe, 1'b0);
        check("gap_sdo", sdo, 1'b0);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, aborted);
        check("rsp_data", rsp_data, exp_rd);
        check("gap_ready0", req_ready, 1'b0);
        @(negedge clk);
        #1;
        check("rsp_valid_pulse", rsp_valid, 1'b0);
        check("gap_ready1", req_ready, 1'b0);
        @(negedge clk);
        #1;
        check("ready_after_gap", req_ready, 1'b1);
    endtask

    initial begin
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_data  = '0;
        sdi       = 1'b0;
        suspend   = 1'b0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_frame", frame, 1'b0);
        check("reset_sdo", sdo, 1'b0);
        check("reset_sdo_oe", sdo_oe, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_data", rsp_data, '0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset_ready", req_ready, 1'b1);

        // Directed steps
        do_frame(2'd0, 8'h02, '0, 0, 0, 0, -1);          // CFG 02
        do_frame(2'd1, 8'hFF, '0, 0, 0, 0, -1);          // START
        do_frame(2'd2, 8'h00, 9'h1A5, 0, 0, 0, -1);      // READ 1A5
        do_frame(2'd0, 8'hA7, '0, 4, 3, 0, -1);          // stall on header bit 4
        do_frame(2'd2, 8'h00, 9'h0F3, HDR_W + TURN_CYC + 2, SUSP_MAX, 0, -1);      // abort
        do_frame(2'd2, 8'h00, 9'h15B, HDR_W + TURN_CYC + 2, SUSP_MAX - 1, 0, -1);  // just short of abort
        do_frame(2'd3, 8'h5C, '0, 0, 0, 0, -1);          // inverted CFG header
        do_frame(2'd1, 8'h00, '0, 0, 0, 5, -1);          // request waits on suspend
        do_frame(2'd0, 8'h81, '0, 0, 0, 0, HDR_W + 2);   // reset mid-DATA
        do_frame(2'd0, 8'h3E, '0, 0, 0, 0, -1);          // normal after reset

        // Randomized frames
        for (int n = 0; n < 16; n++) begin
            do_frame(2'($urandom_range(0, 3)), DATA_W'($urandom), RD_W'($urandom),
                     $urandom_range(0, 20), $urandom_range(0, 4),
                     $urandom_range(0, 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
